// File: rtl/urng_bit_source.sv
// urng_bit_source: serial bit-stream source for rng.bits_in.
// Buffers up to two BX-bit words from a valid/ready port and shifts them
// out LSB-first, one bit per clock. mode=1 substitutes an internal 16-bit
// Galois LFSR so the stream can run without external entropy.
module urng_bit_source #(
   parameter int          BX   = 8,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [BX-1:0] in_word,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          mode,
   input  logic          hold,
   output logic          bits_out,
   output logic          bit_valid,
   output logic          word_start,
   output logic          underrun,
   output logic [15:0]   words_sent
);

   localparam int          IW        = (BX > 1) ? $clog2(BX) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(BX - 1);
   localparam logic [15:0] LFSR_MASK = 16'hB400;
   // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
   localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic [BX-1:0] r_fifo [2];
   logic          r_wr_ptr;
   logic          r_rd_ptr;
   logic [1:0]    r_count;

   state_t        r_state;
   logic          r_src_lfsr;
   logic [IW-1:0] r_bit_idx;
   logic [BX-1:0] r_shreg;
   logic [15:0]   r_lfsr;

   logic          r_bits_out;
   logic          r_bit_valid;
   logic          r_word_start;
   logic          r_underrun;
   logic [15:0]   r_words_sent;

   // ------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------
   logic          w_push;
   logic          w_pop;
   logic          w_fifo_empty;
   logic [BX-1:0] w_head;
   logic          w_at_boundary;
   logic          w_start_lfsr;
   logic          w_start_word;
   logic          w_mid_step;
   logic          w_word_done;
   logic          w_lfsr_step;
   logic [15:0]   w_lfsr_next;

   assign in_ready   = rst && (r_count != 2'd2);
   assign bits_out   = r_bits_out;
   assign bit_valid  = r_bit_valid;
   assign word_start = r_word_start;
   assign underrun   = r_underrun;
   assign words_sent = r_words_sent;

   // Serializer decisions for this edge; mode is only consulted at a word boundary.
   always_comb begin
      w_push        = in_valid && in_ready;
      w_fifo_empty  = (r_count == 2'd0);
      w_head        = r_fifo[r_rd_ptr];
      w_at_boundary = (r_state == S_IDLE) || (r_bit_idx == LAST_IDX);
      w_start_lfsr  = !hold && w_at_boundary && mode;
      w_start_word  = !hold && w_at_boundary && !mode && !w_fifo_empty;
      w_mid_step    = !hold && (r_state == S_SHIFT) && !w_at_boundary;
      w_word_done   = !hold && (r_state == S_SHIFT) && (r_bit_idx == LAST_IDX);
      w_pop         = w_start_word;
      w_lfsr_step   = w_start_lfsr || (w_mid_step && r_src_lfsr);
      if (r_lfsr[0]) begin
         w_lfsr_next = (r_lfsr >> 1) ^ LFSR_MASK;
      end else begin
         w_lfsr_next = r_lfsr >> 1;
      end
   end

   // Two-entry input FIFO: pointer-based storage with an occupancy count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= in_word;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // LFSR advances only on edges that present one of its bits.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_lfsr <= LFSR_INIT;
      end else if (w_lfsr_step) begin
         r_lfsr <= w_lfsr_next;
      end
   end

   // Serializer FSM with registered stream outputs; hold freezes everything but the strobes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_src_lfsr   <= 1'b0;
         r_bit_idx    <= '0;
         r_shreg      <= '0;
         r_bits_out   <= 1'b0;
         r_bit_valid  <= 1'b0;
         r_word_start <= 1'b0;
         r_underrun   <= 1'b0;
         r_words_sent <= '0;
      end else begin
         r_bit_valid  <= 1'b0;
         r_word_start <= 1'b0;
         r_underrun   <= 1'b0;
         if (w_word_done) begin
            r_words_sent <= r_words_sent + 16'd1;
         end
         if (w_start_lfsr) begin
            r_state      <= S_SHIFT;
            r_src_lfsr   <= 1'b1;
            r_bit_idx    <= '0;
            r_bits_out   <= r_lfsr[0];
            r_bit_valid  <= 1'b1;
            r_word_start <= 1'b1;
         end else if (w_start_word) begin
            // Bit 0 goes straight out; the shift register holds the rest.
            r_state      <= S_SHIFT;
            r_src_lfsr   <= 1'b0;
            r_bit_idx    <= '0;
            r_shreg      <= w_head >> 1;
            r_bits_out   <= w_head[0];
            r_bit_valid  <= 1'b1;
            r_word_start <= 1'b1;
         end else if (w_mid_step) begin
            r_bit_idx   <= r_bit_idx + 1'b1;
            r_bit_valid <= 1'b1;
            if (r_src_lfsr) begin
               r_bits_out <= r_lfsr[0];
            end else begin
               r_bits_out <= r_shreg[0];
               r_shreg    <= r_shreg >> 1;
            end
         end else if (w_word_done) begin
            // Boundary with mode 0 and nothing buffered.
            r_state    <= S_IDLE;
            r_underrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_urng_bit_source.sv
// Testbench for urng_bit_source (BX=8, SEED=16'hACE1): table-driven single
// word run followed by directed multi-cycle sequences.
module tb_urng_bit_source;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  in_word = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mode = 1'b0;
   logic        hold = 1'b0;
   logic        bits_out;
   logic        bit_valid;
   logic        word_start;
   logic        underrun;
   logic [15:0] words_sent;

   int n_total = 0;
   int n_bad   = 0;

   urng_bit_source #(.BX(8), .SEED(16'hACE1)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_word    (in_word),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .mode       (mode),
      .hold       (hold),
      .bits_out   (bits_out),
      .bit_valid  (bit_valid),
      .word_start (word_start),
      .underrun   (underrun),
      .words_sent (words_sent)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [7:0]  word;
      logic        valid;
      logic        mode;
      logic        hold;
      logic        e_bit;
      logic        e_bv;
      logic        e_ws;
      logic        e_ur;
      logic        e_rdy;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tv [13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_stream(input string nm, input logic eb, input logic ews);
      chk({nm, ".bv"}, {15'd0, bit_valid}, 16'd1);
      chk({nm, ".bit"}, {15'd0, bits_out}, {15'd0, eb});
      chk({nm, ".ws"}, {15'd0, word_start}, {15'd0, ews});
      chk({nm, ".ur"}, {15'd0, underrun}, 16'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0; in_valid = 1'b0; hold = 1'b0; mode = 1'b0; in_word = 8'h00;
      tick();
      rst = 1'b1;
   endtask

   function automatic vec_t mk(input logic r, input logic [7:0] w, input logic v,
                               input logic b, input logic bv, input logic ws,
                               input logic ur, input logic rdy, input logic [15:0] c);
      vec_t t;
      t.rst = r; t.word = w; t.valid = v; t.mode = 1'b0; t.hold = 1'b0;
      t.e_bit = b; t.e_bv = bv; t.e_ws = ws; t.e_ur = ur; t.e_rdy = rdy; t.e_cnt = c;
      return t;
   endfunction

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  pat;
      logic [23:0] stream;
      logic [15:0] lfsr_bits;

      // ---- Test 1: single word 8'hA5, table driven ----
      //           rst word  v  bit bv ws ur rdy cnt
      tv[0]  = mk(0, 8'h00, 0,  0, 0, 0, 0, 0, 0);
      tv[1]  = mk(1, 8'h00, 0,  0, 0, 0, 0, 1, 0);
      tv[2]  = mk(1, 8'hA5, 1,  0, 0, 0, 0, 1, 0);
      tv[3]  = mk(1, 8'h00, 0,  1, 1, 1, 0, 1, 0);
      tv[4]  = mk(1, 8'h00, 0,  0, 1, 0, 0, 1, 0);
      tv[5]  = mk(1, 8'h00, 0,  1, 1, 0, 0, 1, 0);
      tv[6]  = mk(1, 8'h00, 0,  0, 1, 0, 0, 1, 0);
      tv[7]  = mk(1, 8'h00, 0,  0, 1, 0, 0, 1, 0);
      tv[8]  = mk(1, 8'h00, 0,  1, 1, 0, 0, 1, 0);
      tv[9]  = mk(1, 8'h00, 0,  0, 1, 0, 0, 1, 0);
      tv[10] = mk(1, 8'h00, 0,  1, 1, 0, 0, 1, 0);
      tv[11] = mk(1, 8'h00, 0,  1, 0, 0, 1, 1, 1);
      tv[12] = mk(1, 8'h00, 0,  1, 0, 0, 0, 1, 1);
      for (int i = 0; i < 13; i++) begin
         rst = tv[i].rst; in_word = tv[i].word; in_valid = tv[i].valid;
         mode = tv[i].mode; hold = tv[i].hold;
         tick();
         chk($sformatf("t1[%0d].bit", i), {15'd0, bits_out}, {15'd0, tv[i].e_bit});
         chk($sformatf("t1[%0d].bv", i), {15'd0, bit_valid}, {15'd0, tv[i].e_bv});
         chk($sformatf("t1[%0d].ws", i), {15'd0, word_start}, {15'd0, tv[i].e_ws});
         chk($sformatf("t1[%0d].ur", i), {15'd0, underrun}, {15'd0, tv[i].e_ur});
         chk($sformatf("t1[%0d].rdy", i), {15'd0, in_ready}, {15'd0, tv[i].e_rdy});
         chk($sformatf("t1[%0d].cnt", i), words_sent, tv[i].e_cnt);
      end

      // ---- Test 2: back-to-back 01, FF, 80 ----
      do_reset();
      stream = 24'h80FF01;
      in_word = 8'h01; in_valid = 1'b1;
      tick();
      chk("t2.rdy_after1", {15'd0, in_ready}, 16'd1);
      in_word = 8'hFF;
      tick();
      chk_stream("t2.b0", stream[0], 1'b1);
      in_word = 8'h80;
      tick();
      chk("t2.rdy_full", {15'd0, in_ready}, 16'd0);
      chk_stream("t2.b1", stream[1], 1'b0);
      in_valid = 1'b0;
      for (int i = 2; i < 24; i++) begin
         tick();
         chk_stream($sformatf("t2.b%0d", i), stream[i], (i % 8) == 0);
      end
      tick();
      chk("t2.end_bv", {15'd0, bit_valid}, 16'd0);
      chk("t2.end_ur", {15'd0, underrun}, 16'd1);
      chk("t2.end_cnt", words_sent, 16'd3);
      chk("t2.end_rdy", {15'd0, in_ready}, 16'd1);
      tick();
      chk("t2.ur_pulse", {15'd0, underrun}, 16'd0);

      // ---- Test 3: hold during 8'h0F, and hold across the word boundary ----
      do_reset();
      pat = 8'h0F;
      in_word = pat; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_stream($sformatf("t3.b%0d", k), pat[k], k == 0);
      end
      hold = 1'b1;
      for (int h = 0; h < 3; h++) begin
         tick();
         chk($sformatf("t3.hold%0d.bv", h), {15'd0, bit_valid}, 16'd0);
         chk($sformatf("t3.hold%0d.ur", h), {15'd0, underrun}, 16'd0);
         chk($sformatf("t3.hold%0d.bit", h), {15'd0, bits_out}, 16'd1);
      end
      hold = 1'b0;
      for (int k = 3; k < 8; k++) begin
         tick();
         chk_stream($sformatf("t3.b%0d", k), pat[k], 1'b0);
      end
      hold = 1'b1;
      tick();
      chk("t3.bhold.ur", {15'd0, underrun}, 16'd0);
      chk("t3.bhold.cnt", words_sent, 16'd0);
      hold = 1'b0;
      tick();
      chk("t3.end_ur", {15'd0, underrun}, 16'd1);
      chk("t3.end_cnt", words_sent, 16'd1);

      // ---- Test 4: LFSR mode from SEED 16'hACE1 ----
      do_reset();
      lfsr_bits = 16'hC4E1;
      mode = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         chk_stream($sformatf("t4.b%0d", k), lfsr_bits[k], (k % 8) == 0);
         if (k == 8) chk("t4.cnt8", words_sent, 16'd1);
      end
      tick();
      chk("t4.ws16", {15'd0, word_start}, 16'd1);
      chk("t4.cnt16", words_sent, 16'd2);
      chk("t4.ur16", {15'd0, underrun}, 16'd0);

      // ---- Test 5: reset mid-word with a second word queued ----
      do_reset();
      in_word = 8'hA5; in_valid = 1'b1;
      tick();
      in_word = 8'h5A;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("t5.pre_bit2", {15'd0, bits_out}, 16'd1);
      rst = 1'b0;
      tick();
      chk("t5.rst.bit", {15'd0, bits_out}, 16'd0);
      chk("t5.rst.bv", {15'd0, bit_valid}, 16'd0);
      chk("t5.rst.ws", {15'd0, word_start}, 16'd0);
      chk("t5.rst.ur", {15'd0, underrun}, 16'd0);
      chk("t5.rst.cnt", words_sent, 16'd0);
      chk("t5.rst.rdy", {15'd0, in_ready}, 16'd0);
      rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk($sformatf("t5.idle%0d.bv", i), {15'd0, bit_valid}, 16'd0);
         chk($sformatf("t5.idle%0d.ur", i), {15'd0, underrun}, 16'd0);
      end
      chk("t5.idle.rdy", {15'd0, in_ready}, 16'd1);
      in_word = 8'h02; in_valid = 1'b1;
      tick();
      chk("t5.push.bv", {15'd0, bit_valid}, 16'd0);
      in_valid = 1'b0;
      tick();
      chk_stream("t5.new.b0", 1'b0, 1'b1);
      tick();
      chk_stream("t5.new.b1", 1'b1, 1'b0);

      // ---- Test 6: mode switch mid-word, word queued during LFSR mode ----
      do_reset();
      pat = 8'h33;
      in_word = pat; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_stream($sformatf("t6.w0.b%0d", k), pat[k], k == 0);
      end
      mode = 1'b1;
      for (int k = 5; k < 8; k++) begin
         tick();
         chk_stream($sformatf("t6.w0.b%0d", k), pat[k], 1'b0);
      end
      lfsr_bits = 16'hC4E1;
      tick();
      chk_stream("t6.l.b0", lfsr_bits[0], 1'b1);
      chk("t6.l.cnt", words_sent, 16'd1);
      in_word = 8'h96; in_valid = 1'b1;
      tick();
      chk_stream("t6.l.b1", lfsr_bits[1], 1'b0);
      chk("t6.l.rdy", {15'd0, in_ready}, 16'd1);
      in_valid = 1'b0;
      mode = 1'b0;
      for (int k = 2; k < 8; k++) begin
         tick();
         chk_stream($sformatf("t6.l.b%0d", k), lfsr_bits[k], 1'b0);
      end
      pat = 8'h96;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk_stream($sformatf("t6.w1.b%0d", k), pat[k], k == 0);
         if (k == 0) chk("t6.w1.cnt", words_sent, 16'd2);
      end
      tick();
      chk("t6.end_bv", {15'd0, bit_valid}, 16'd0);
      chk("t6.end_ur", {15'd0, underrun}, 16'd1);
      chk("t6.end_cnt", words_sent, 16'd3);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
